axi_lite_slave_bridge: RTL and testbench

- Parametrised AXI4-Lite slave that converts AXI read/write transactions into a single-outstanding valid/ready memory-style request on the adapter interface.
- Generalises the existing 32-bit slave adapter with configurable data/address width and fair read/write arbitration.
- Out-of-range addresses complete with DECERR instead of stalling the bus.
- Sits between the interconnect and one peripheral/memory block; one transaction in flight at a time.

---
 rtl/axi_lite_slave_bridge_if.sv | 41 ++++
 rtl/axi_lite_slave_bridge.sv | 223 ++++++++++++++++++++++
 tb/tb_axi_lite_slave_bridge.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_slave_bridge_if.sv
// AXI4-Lite bus bundle between an interconnect (master) and the bridge (slave).
interface axi_lite_slave_bridge_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0] S_AXI_RDATA;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;
  logic [1:0]            S_AXI_RRESP;
  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic                  S_AXI_AWVALID;
  logic                  S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0] S_AXI_WDATA;
  logic [STRB_W-1:0]     S_AXI_WSTRB;
  logic                  S_AXI_WVALID;
  logic                  S_AXI_WREADY;
  logic [1:0]            S_AXI_BRESP;
  logic                  S_AXI_BVALID;
  logic                  S_AXI_BREADY;

  modport slave (
    input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
           S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RVALID, S_AXI_RRESP,
           S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
  );

  modport master (
    output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
           S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RVALID, S_AXI_RRESP,
           S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
  );
endinterface

// File: rtl/axi_lite_slave_bridge.sv
// AXI4-Lite slave to single-outstanding valid/ready memory request bridge.
// Optional watchdog on the memory request: define AXI_SLAVE_TIMEOUT_EN.
module axi_lite_slave_bridge #(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR     = 'h4000_0000,
  parameter logic [ADDR_WIDTH-1:0] END_ADDR       = 'h4000_4000,
  parameter int unsigned           TIMEOUT_CYCLES = 256,
  localparam int unsigned          STRB_W         = DATA_WIDTH / 8
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    reset_i,
  output logic                    clk_o,
  axi_lite_slave_bridge_if.slave  s_axi,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [STRB_W-1:0]       wstrb_o,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  input  logic [DATA_WIDTH-1:0]   rdata_i
);

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
    $error("DATA_WIDTH must be 32 or 64");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_ADDR    = 3'd1,
    RD_MEM     = 3'd2,
    RD_RESP    = 3'd3,
    WR_COLLECT = 3'd4,
    WR_MEM     = 3'd5,
    WR_RESP    = 3'd6
  } state_e;

  typedef struct packed {
    state_e                state;
    logic                  last_wr;
    logic                  arready;
    logic                  awready;
    logic                  wready;
    logic                  rvalid;
    logic                  bvalid;
    logic                  valid;
    logic [1:0]            rresp;
    logic [1:0]            bresp;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ADDR_WIDTH-1:0] addr;
    logic [STRB_W-1:0]     wstrb;
    logic                  aw_done;
    logic                  w_done;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [STRB_W-1:0]     lat_wstrb;
  } regs_t;

  regs_t r_q, r_d;

  logic                  aw_hs, w_hs, mem_done, mem_tmo;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >= START_ADDR) && (a < END_ADDR);
  endfunction

`ifdef AXI_SLAVE_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_ff @(posedge S_AXI_ACLK) begin
    if (reset_i) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`endif

  // NOTE: state is written only with <= so every register sees pre-edge values.
  always_ff @(posedge S_AXI_ACLK) begin
    if (reset_i) r_q <= '0;
    else         r_q <= r_d;
  end

  // NOTE: r_d starts as a copy of r_q so no path through this block leaves it unassigned.
  always_comb begin
    r_d      = r_q;
    aw_hs    = r_q.awready & s_axi.S_AXI_AWVALID;
    w_hs     = r_q.wready & s_axi.S_AXI_WVALID;
    wr_addr  = aw_hs ? s_axi.S_AXI_AWADDR : r_q.lat_addr;
    wr_data  = w_hs ? s_axi.S_AXI_WDATA : r_q.lat_wdata;
    wr_strb  = w_hs ? s_axi.S_AXI_WSTRB : r_q.lat_wstrb;
    mem_done = ready_i;
    mem_tmo  = 1'b0;
`ifdef AXI_SLAVE_TIMEOUT_EN
    tmo_d    = '0;
    if (!ready_i && (r_q.state == RD_MEM || r_q.state == WR_MEM)) begin
      mem_tmo = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
      tmo_d   = tmo_q + 1'b1;
    end
`endif

    // A finished or timed-out memory request tears down the adapter side.
    if ((mem_done || mem_tmo) && (r_q.state == RD_MEM || r_q.state == WR_MEM)) begin
      r_d.valid = 1'b0;
      r_d.addr  = '0;
      r_d.wdata = '0;
      r_d.wstrb = '0;
    end

    case (r_q.state)
      IDLE: begin
        if (s_axi.S_AXI_ARVALID && (!s_axi.S_AXI_AWVALID || r_q.last_wr)) begin
          r_d.state   = RD_ADDR;
          r_d.arready = 1'b1;
          r_d.last_wr = 1'b0;
        end else if (s_axi.S_AXI_AWVALID) begin
          r_d.state   = WR_COLLECT;
          r_d.awready = 1'b1;
          r_d.wready  = 1'b1;
          r_d.aw_done = 1'b0;
          r_d.w_done  = 1'b0;
          r_d.last_wr = 1'b1;
        end
      end
      RD_ADDR: begin
        if (s_axi.S_AXI_ARVALID) begin
          r_d.arready = 1'b0;
          if (in_range(s_axi.S_AXI_ARADDR)) begin
            r_d.state = RD_MEM;
            r_d.valid = 1'b1;
            r_d.addr  = s_axi.S_AXI_ARADDR;
            r_d.wstrb = '0;
          end else begin
            r_d.state  = RD_RESP;
            r_d.rvalid = 1'b1;
            r_d.rresp  = 2'b11;
            r_d.rdata  = '0;
          end
        end
      end
      RD_MEM: begin
        if (mem_done || mem_tmo) begin
          r_d.state  = RD_RESP;
          r_d.rvalid = 1'b1;
          r_d.rresp  = mem_done ? 2'b00 : 2'b10;
          r_d.rdata  = mem_done ? rdata_i : '0;
        end
      end
      RD_RESP: begin
        if (s_axi.S_AXI_RREADY) begin
          r_d.state  = IDLE;
          r_d.rvalid = 1'b0;
          r_d.rresp  = 2'b00;
          r_d.rdata  = '0;
        end
      end
      WR_COLLECT: begin
        if (aw_hs) begin
          r_d.awready  = 1'b0;
          r_d.aw_done  = 1'b1;
          r_d.lat_addr = s_axi.S_AXI_AWADDR;
        end
        if (w_hs) begin
          r_d.wready    = 1'b0;
          r_d.w_done    = 1'b1;
          r_d.lat_wdata = s_axi.S_AXI_WDATA;
          r_d.lat_wstrb = s_axi.S_AXI_WSTRB;
        end
        if ((r_q.aw_done || aw_hs) && (r_q.w_done || w_hs)) begin
          r_d.aw_done = 1'b0;
          r_d.w_done  = 1'b0;
          if (in_range(wr_addr)) begin
            r_d.state = WR_MEM;
            r_d.valid = 1'b1;
            r_d.addr  = wr_addr;
            r_d.wdata = wr_data;
            r_d.wstrb = wr_strb;
          end else begin
            r_d.state  = WR_RESP;
            r_d.bvalid = 1'b1;
            r_d.bresp  = 2'b11;
          end
        end
      end
      WR_MEM: begin
        if (mem_done || mem_tmo) begin
          r_d.state  = WR_RESP;
          r_d.bvalid = 1'b1;
          r_d.bresp  = mem_done ? 2'b00 : 2'b10;
        end
      end
      WR_RESP: begin
        if (s_axi.S_AXI_BREADY) begin
          r_d.state  = IDLE;
          r_d.bvalid = 1'b0;
          r_d.bresp  = 2'b00;
        end
      end
      default: r_d = '0;
    endcase
  end

  assign clk_o   = S_AXI_ACLK;
  assign valid_o = r_q.valid;
  assign wstrb_o = r_q.wstrb;
  assign addr_o  = r_q.addr;
  assign wdata_o = r_q.wdata;

  assign s_axi.S_AXI_ARREADY = r_q.arready;
  assign s_axi.S_AXI_RDATA   = r_q.rdata;
  assign s_axi.S_AXI_RVALID  = r_q.rvalid;
  assign s_axi.S_AXI_RRESP   = r_q.rresp;
  assign s_axi.S_AXI_AWREADY = r_q.awready;
  assign s_axi.S_AXI_WREADY  = r_q.wready;
  assign s_axi.S_AXI_BRESP   = r_q.bresp;
  assign s_axi.S_AXI_BVALID  = r_q.bvalid;

endmodule

// File: tb/tb_axi_lite_slave_bridge.sv
// Directed scoreboard bench for axi_lite_slave_bridge (32-bit data/address).
module tb_axi_lite_slave_bridge;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    logic        is_wr;
    logic [1:0]  resp;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        clk_o;
  logic        valid_o;
  logic        ready_i;
  logic [3:0]  wstrb_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic [31:0] rdata_i;

  int errors = 0;
  int checks = 0;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int   grant_log[$];
  int   req_seen = 0;
  logic log_en = 1'b0;
  logic valid_prev = 1'b0;
  logic ar_prev = 1'b0;
  logic aw_prev = 1'b0;

  axi_lite_slave_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  axi_lite_slave_bridge #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .START_ADDR    (32'h4000_0000),
    .END_ADDR      (32'h4000_4000),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .S_AXI_ACLK(clk),
    .reset_i   (reset_i),
    .clk_o     (clk_o),
    .s_axi     (bus),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .wstrb_o   (wstrb_o),
    .addr_o    (addr_o),
    .wdata_o   (wdata_o),
    .rdata_i   (rdata_i)
  );

  always #5 clk = ~clk;

  // Counts adapter requests and records grant order on the falling edge.
  always @(negedge clk) begin
    if (valid_o && !valid_prev) req_seen <= req_seen + 1;
    if (log_en && bus.S_AXI_ARREADY && !ar_prev) grant_log.push_back(0);
    if (log_en && bus.S_AXI_AWREADY && !aw_prev) grant_log.push_back(1);
    valid_prev <= valid_o;
    ar_prev    <= bus.S_AXI_ARREADY;
    aw_prev    <= bus.S_AXI_AWREADY;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ready_i            = 1'b0;
    rdata_i            = 32'hFFFF_FFFF;
    bus.S_AXI_ARADDR   = '0;
    bus.S_AXI_ARVALID  = 1'b0;
    bus.S_AXI_RREADY   = 1'b0;
    bus.S_AXI_AWADDR   = '0;
    bus.S_AXI_AWVALID  = 1'b0;
    bus.S_AXI_WDATA    = '0;
    bus.S_AXI_WSTRB    = '0;
    bus.S_AXI_WVALID   = 1'b0;
    bus.S_AXI_BREADY   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_i = 1'b1;
    repeat (3) tick();
    reset_i = 1'b0;
    tick();
  endtask

  task automatic push_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_t r;
    r.addr = a; r.wdata = d; r.wstrb = s;
    req_q.push_back(r);
  endtask

  task automatic push_rsp(input logic w, input logic [1:0] resp, input logic [31:0] d);
    rsp_t r;
    r.is_wr = w; r.resp = resp; r.data = d;
    rsp_q.push_back(r);
  endtask

  // Read address handshake; ARVALID drops after the edge on which ARREADY was seen.
  task automatic ar_issue(input logic [31:0] a);
    int n = 0;
    bus.S_AXI_ARADDR  = a;
    bus.S_AXI_ARVALID = 1'b1;
    while (!bus.S_AXI_ARREADY && n < 20) begin tick(); n++; end
    check("ar_ready_timeout", bus.S_AXI_ARREADY, 1);
    tick();
    bus.S_AXI_ARVALID = 1'b0;
  endtask

  // AW and W handshakes, each dropped independently once accepted.
  task automatic wr_handshake();
    logic aw_ok = 1'b0;
    logic w_ok  = 1'b0;
    for (int i = 0; i < 20 && !(aw_ok && w_ok); i++) begin
      logic aw_fire, w_fire;
      aw_fire = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_fire  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      tick();
      if (aw_fire) begin bus.S_AXI_AWVALID = 1'b0; aw_ok = 1'b1; end
      if (w_fire)  begin bus.S_AXI_WVALID  = 1'b0; w_ok  = 1'b1; end
    end
    check("wr_handshake_timeout", {aw_ok, w_ok}, 2'b11);
  endtask

  task automatic wait_valid();
    int n = 0;
    req_t r;
    while (!valid_o && n < 20) begin tick(); n++; end
    check("valid_timeout", valid_o, 1);
    check("req_sb_nonempty", req_q.size() > 0, 1);
    if (valid_o && req_q.size() > 0) begin
      r = req_q.pop_front();
      check("req_addr", addr_o, r.addr);
      check("req_wdata", wdata_o, r.wdata);
      check("req_wstrb", wstrb_o, r.wstrb);
    end
  endtask

  // Serve one adapter request, asserting ready_i `delay` cycles after valid_o.
  task automatic serve_mem(input int delay, input logic [31:0] d);
    logic [31:0] a;
    wait_valid();
    a = addr_o;
    for (int i = 0; i < delay; i++) begin
      tick();
      check("req_hold", {valid_o, addr_o}, {1'b1, a});
    end
    ready_i = 1'b1;
    rdata_i = d;
    tick();
    ready_i = 1'b0;
    rdata_i = 32'hFFFF_FFFF;
    check("req_drop", {valid_o, wstrb_o, addr_o, wdata_o}, '0);
  endtask

  task automatic take_rsp(input logic w, input int hold);
    int   n = 0;
    rsp_t r;
    while (!(w ? bus.S_AXI_BVALID : bus.S_AXI_RVALID) && n < 40) begin tick(); n++; end
    check("rsp_timeout", w ? bus.S_AXI_BVALID : bus.S_AXI_RVALID, 1);
    check("rsp_sb_nonempty", rsp_q.size() > 0, 1);
    if (rsp_q.size() > 0) begin
      r = rsp_q.pop_front();
      if (w) check("bresp", bus.S_AXI_BRESP, r.resp);
      else   check("rresp_rdata", {bus.S_AXI_RRESP, bus.S_AXI_RDATA}, {r.resp, r.data});
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      check("rsp_hold", w ? bus.S_AXI_BVALID : bus.S_AXI_RVALID, 1);
    end
    if (w) bus.S_AXI_BREADY = 1'b1; else bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    check("rsp_clear", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
  endtask

  initial begin
    int seen0;
    do_reset();

    // Reset state
    check("rst_axi_ctrl", {bus.S_AXI_ARREADY, bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
                           bus.S_AXI_RVALID, bus.S_AXI_BVALID, bus.S_AXI_RRESP,
                           bus.S_AXI_BRESP}, '0);
    check("rst_rdata", bus.S_AXI_RDATA, 0);
    check("rst_adapter", {valid_o, wstrb_o, addr_o[27:0], wdata_o}, '0);
    check("rst_addr_hi", addr_o[31:28], 0);
    check("clk_o", clk_o, clk);

    // In-range read with exact latency: ARREADY at 1, valid_o at 2, ready_i at 5, RVALID at 6
    seen0 = req_seen;
    push_req(32'h4000_0010, 32'h0, 4'h0);
    push_rsp(1'b0, 2'b00, 32'hDEAD_BEEF);
    bus.S_AXI_ARADDR  = 32'h4000_0010;
    bus.S_AXI_ARVALID = 1'b1;
    tick();
    check("rd_c1_arready_valid", {bus.S_AXI_ARREADY, valid_o}, 2'b10);
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    check("rd_c2_arready_valid", {bus.S_AXI_ARREADY, valid_o}, 2'b01);
    serve_mem(3, 32'hDEAD_BEEF);
    check("rd_rvalid_after_ready", bus.S_AXI_RVALID, 1);
    take_rsp(1'b0, 0);
    check("rd_one_request", req_seen - seen0, 1);
    tick();

    // Write with W beat four cycles ahead of AW; BREADY withheld for five cycles
    seen0 = req_seen;
    bus.S_AXI_WDATA  = 32'h1234_5678;
    bus.S_AXI_WSTRB  = 4'b0011;
    bus.S_AXI_WVALID = 1'b1;
    repeat (4) tick();
    check("w_alone_no_start", {bus.S_AXI_WREADY, bus.S_AXI_AWREADY, valid_o}, 3'b000);
    push_req(32'h4000_0FFC, 32'h1234_5678, 4'b0011);
    push_rsp(1'b1, 2'b00, 32'h0);
    bus.S_AXI_AWADDR  = 32'h4000_0FFC;
    bus.S_AXI_AWVALID = 1'b1;
    wr_handshake();
    serve_mem(2, 32'h0);
    take_rsp(1'b1, 5);
    check("wr_one_request", req_seen - seen0, 1);
    tick();

    // Out-of-range read at END_ADDR: RVALID at cycle 2, DECERR, no adapter request
    seen0   = req_seen;
    ready_i = 1'b1;
    push_rsp(1'b0, 2'b11, 32'h0);
    bus.S_AXI_ARADDR  = 32'h4000_4000;
    bus.S_AXI_ARVALID = 1'b1;
    tick();
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    check("oor_rd_c2_rvalid", {bus.S_AXI_RVALID, valid_o}, 2'b10);
    take_rsp(1'b0, 1);
    ready_i = 1'b0;
    tick();

    // Out-of-range write below START_ADDR: W still accepted, DECERR
    push_rsp(1'b1, 2'b11, 32'h0);
    bus.S_AXI_AWADDR  = 32'h3FFF_FFFC;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = 32'hCAFE_F00D;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_WVALID  = 1'b1;
    wr_handshake();
    take_rsp(1'b1, 0);
    check("oor_no_request", req_seen - seen0, 0);
    tick();

    // Round-robin with both address channels held: write, read, write, read
    do_reset();
    ready_i           = 1'b1;
    rdata_i           = 32'hA5A5_A5A5;
    bus.S_AXI_RREADY  = 1'b1;
    bus.S_AXI_BREADY  = 1'b1;
    bus.S_AXI_ARADDR  = 32'h4000_0020;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_AWADDR  = 32'h4000_0030;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = 32'h0BAD_CAFE;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_WVALID  = 1'b1;
    log_en = 1'b1;
    for (int i = 0; i < 200 && grant_log.size() < 4; i++) tick();
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    repeat (10) tick();
    log_en = 1'b0;
    check("rr_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check($sformatf("rr_grant_%0d_is_write", i), grant_log[i], (i % 2 == 0) ? 1 : 0);
    check("rr_drained", {valid_o, bus.S_AXI_RVALID, bus.S_AXI_BVALID}, 3'b000);
    clear_inputs();
    tick();

    // Reset during RD_MEM aborts; the next read completes normally
    push_req(32'h4000_0100, 32'h0, 4'h0);
    ar_issue(32'h4000_0100);
    wait_valid();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("abort_outputs", {valid_o, bus.S_AXI_RVALID}, 2'b00);
    tick();
    push_req(32'h4000_0104, 32'h0, 4'h0);
    push_rsp(1'b0, 2'b00, 32'h5555_AAAA);
    ar_issue(32'h4000_0104);
    serve_mem(1, 32'h5555_AAAA);
    take_rsp(1'b0, 0);
    tick();

    // Stuck adapter: SLVERR after 16 cycles with the watchdog, indefinite wait without
    push_req(32'h4000_0200, 32'h0, 4'h0);
    ar_issue(32'h4000_0200);
    wait_valid();
`ifdef AXI_SLAVE_TIMEOUT_EN
    push_rsp(1'b0, 2'b10, 32'h0);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("tmo_valid_held", valid_o, 1);
    end
    tick();
    check("tmo_valid_drop", {valid_o, bus.S_AXI_RVALID}, 2'b01);
    take_rsp(1'b0, 0);
`else
    push_rsp(1'b0, 2'b00, 32'h7777_1111);
    repeat (40) tick();
    check("no_tmo_valid_held", {valid_o, bus.S_AXI_RVALID}, 2'b10);
    ready_i = 1'b1;
    rdata_i = 32'h7777_1111;
    tick();
    ready_i = 1'b0;
    take_rsp(1'b0, 0);
`endif
    check("sb_drained", {32'(req_q.size()), 32'(rsp_q.size())}, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
